call_queue: RTL
===============

// Module: call_queue
// PURPOSE
// - Upstream stage of the elevator FSM: replaces the pure combinational call decode with call memory.
// - Synchronises and debounces the 6 call buttons (external A_e/B_e/C_e, internal A_i/B_i/C_i).
// - Latches them as pending per floor and selects one target floor with a direction-holding (SCAN) policy.
// - Drives B1:B0 into mef_elevator/door_var; clears a call once the car is at that floor with the door open.
// PARAMETERS
// - DEB_CYCLES   500000  clk cycles an input must stay stable before it is accepted (10 ms @ 50 MHz)
// - SYNC_STAGES  2       flip-flop synchroniser depth per button input
// PORTS
// - clk          in   1  board clock (undivided); all state in this single domain
// - reset        in   1  asynchronous, active-low reset
// - A_e,B_e,C_e  in   1  external hall call buttons, floors A/B/C, active-high, asynchronous
// - A_i,B_i,C_i  in   1  car-internal call buttons, floors A/B/C, active-high, asynchronous
// - EA           in   2  current floor from mef_elevator: 00=A, 01=B, 10=C, 11=invalid (treated as no clear)
// - door_closed  in   1  door state from mef_door: 1=closed, 0=open
// - B1,B0        out  1  target code {B1,B0}: 00=no call, 01=A, 10=B, 11=C
// - pending      out  3  pending[0]=A, [1]=B, [2]=C (internal OR external), for LEDs
// - dir_up       out  1  1 = current sweep direction is upward (A->C)
// BEHAVIOUR
// - Reset (reset=0, async): sync/debounce regs 0, pending=000, state=IDLE, {B1,B0}=00, dir_up=1.
// - Input path: SYNC_STAGES-FF synchroniser -> debounce counter; accepted level changes only after
//   DEB_CYCLES consecutive identical samples; a call is registered on accepted 0->1 edge only.
//   A held button produces one registration; release/re-press needed for another.
// - Pending: req[f] = accepted edge on f_e OR f_i. clr[f] = (EA==f) & !door_closed.
//   pending[f] <= clr[f] ? 0 : (pending[f] | req[f]). Clear wins over simultaneous request.
// - Latency: accepted edge -> pending bit next cycle -> {B1,B0} updated the cycle after (2 cycles).
// - Direction FSM (registered), evaluated every cycle from registered pending and EA:
//   IDLE: pending==0 -> stay, target 00. Else go UP if any pending floor > EA, else DOWN if any < EA;
//         if only the current floor is pending (door closed) -> stay IDLE, target = EA.
//         Tie from B with both A and C pending -> UP (upward preference).
//   UP:   pending above EA -> target = nearest above. Else pending below -> DOWN. Else IDLE.
//   DOWN: mirror of UP. dir_up = (state!=DOWN).
//   In all states a pending call at EA with door closed overrides: target = EA (door re-opens).
// - Target hold: {B1,B0} changes only while door_closed=0 or while the current target is no longer pending;
//   never retargets mid-travel to a floor behind the sweep.
// - EA=11: no clears, target frozen at last value, FSM state frozen.
// - reset asserted mid-travel: all pending calls lost, {B1,B0}=00 asynchronously.
// - Width rules: floor index 0..2 compared as unsigned 2-bit; counter width = $clog2(DEB_CYCLES+1).
// STRUCTURE
// - elevator_pkg: floor codes FLOOR_A/B/C (2'b00/01/10), target codes TGT_NONE/A/B/C,
//   direction state enum {IDLE, UP, DOWN}. Shared with mef_elevator and Display.
// - Sub-module call_debounce (SYNC_STAGES, DEB_CYCLES): clk, reset, raw in -> 1-cycle rise pulse out;
//   instantiated 6x. call_queue holds pending regs, direction FSM and target register.
// TESTING (bench uses DEB_CYCLES=4)
// - Reset: reset=0 with buttons held -> B1B0=00, pending=000, dir_up=1; release reset, no registration until edge.
// - Bounce: B_e toggles every cycle for 10 cycles then stays 0 -> pending stays 000; stable 1 for 5 cycles ->
//   pending=010, B1B0=10 two cycles after acceptance.
// - Sweep: EA=00, pending A-none, press C_i then B_e -> UP, target 10 (B) first; at EA=01 door open ->
//   pending[1] cleared, next target 11 (C).
// - Reversal: EA=10, state UP, pending=001 -> DOWN, dir_up=0, B1B0=01.
// - Simultaneous: EA=01, door_closed=0, B_i edge same cycle -> pending[1] stays 0; A_e same cycle -> pending[0]=1.
// - Mid-op reset: pending=101, target 11, pulse reset low -> all outputs reset immediately, no stale target after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared floor/target codes and sweep-direction state for the elevator blocks.
package elevator_pkg;

   // Floor codes as reported on EA
   localparam logic [1:0] FLOOR_A   = 2'b00;
   localparam logic [1:0] FLOOR_B   = 2'b01;
   localparam logic [1:0] FLOOR_C   = 2'b10;
   localparam logic [1:0] FLOOR_INV = 2'b11;

   // Target codes driven on {B1,B0}
   localparam logic [1:0] TGT_NONE = 2'b00;
   localparam logic [1:0] TGT_A    = 2'b01;
   localparam logic [1:0] TGT_B    = 2'b10;
   localparam logic [1:0] TGT_C    = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } dir_state_t;

   // A valid floor code maps onto its target code by adding one
   function automatic logic [1:0] floor_to_tgt(input logic [1:0] floor);
      return floor + 2'd1;
   endfunction

endpackage

// File: rtl/call_debounce.sv
// Button input conditioner: synchroniser, stability filter, and a one-cycle
// pulse when the accepted level goes from released to pressed.
module call_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic rise
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   rise_q, rise_d;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = rise_q;

   // Shift the raw button in; count consecutive samples that disagree with the accepted level
   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = raw_in;
      cnt_d     = '0;
      stable_d  = stable_q;
      rise_d    = 1'b0;
      if (sync_out != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_out;
            rise_d   = sync_out;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset forgets any half-filtered press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

endmodule

// File: rtl/call_queue.sv
// Call memory for the elevator: debounced buttons latch pending floors and a
// direction-holding sweep picks the target floor presented on {B1,B0}.
module call_queue
   import elevator_pkg::*;
#(
   parameter int DEB_CYCLES  = 500000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       A_e,
   input  logic       B_e,
   input  logic       C_e,
   input  logic       A_i,
   input  logic       B_i,
   input  logic       C_i,
   input  logic [1:0] EA,
   input  logic       door_closed,
   output logic       B1,
   output logic       B0,
   output logic [2:0] pending,
   output logic       dir_up
);

   logic [5:0] raw_btn;
   logic [5:0] btn_rise;
   logic [2:0] req;

   logic [2:0] pend_q, pend_d;
   dir_state_t state_q, state_d;
   logic [1:0] tgt_q, tgt_d;

   logic       ea_valid, above, below, here, tgt_pending;
   logic [1:0] near_up, near_dn, cand;

   // Hall buttons in the low half, car buttons in the high half, floor order A/B/C
   assign raw_btn = {C_i, B_i, A_i, C_e, B_e, A_e};

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_btn
         call_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
         ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw_in(raw_btn[gi]),
            .rise  (btn_rise[gi])
         );
      end
   endgenerate

   assign req = btn_rise[2:0] | btn_rise[5:3];

   // Pending-call update, sweep decision and target selection
   always_comb begin
      ea_valid = (EA != FLOOR_INV);

      // A floor being served (car there, door open) cannot be re-requested in the same cycle
      for (int f = 0; f < 3; f++) begin
         if (ea_valid && (EA == 2'(f)) && !door_closed) begin
            pend_d[f] = 1'b0;
         end else begin
            pend_d[f] = pend_q[f] | req[f];
         end
      end

      above   = ((EA == FLOOR_A) && (pend_q[1] || pend_q[2])) ||
                ((EA == FLOOR_B) && pend_q[2]);
      below   = ((EA == FLOOR_C) && (pend_q[0] || pend_q[1])) ||
                ((EA == FLOOR_B) && pend_q[0]);
      here    = ((EA == FLOOR_A) && pend_q[0]) ||
                ((EA == FLOOR_B) && pend_q[1]) ||
                ((EA == FLOOR_C) && pend_q[2]);
      near_up = ((EA == FLOOR_A) && pend_q[1]) ? TGT_B : TGT_C;
      near_dn = ((EA == FLOOR_C) && pend_q[1]) ? TGT_B : TGT_A;

      tgt_pending = ((tgt_q == TGT_A) && pend_q[0]) ||
                    ((tgt_q == TGT_B) && pend_q[1]) ||
                    ((tgt_q == TGT_C) && pend_q[2]);

      state_d = state_q;
      tgt_d   = tgt_q;
      cand    = TGT_NONE;

      // Floor code 11 means the car is between floors: freeze direction and target
      if (ea_valid) begin
         if (state_q == DOWN) begin
            state_d = below ? DOWN : (above ? UP : IDLE);
         end else begin
            state_d = above ? UP : (below ? DOWN : IDLE);
         end

         case (state_d)
            UP:      cand = near_up;
            DOWN:    cand = near_dn;
            default: cand = here ? floor_to_tgt(EA) : TGT_NONE;
         endcase

         // A call at the current floor with the door shut re-opens the door first
         if (here && door_closed) begin
            cand = floor_to_tgt(EA);
         end

         // While travelling towards a still-pending target, keep it
         if (!(door_closed && tgt_pending)) begin
            tgt_d = cand;
         end
      end
   end

   // Registered outputs; reset drops every call and clears the target at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q  <= 3'b000;
         state_q <= IDLE;
         tgt_q   <= TGT_NONE;
      end else begin
         pend_q  <= pend_d;
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   assign {B1, B0} = tgt_q;
   assign pending  = pend_q;
   assign dir_up   = (state_q != DOWN);

endmodule
